// File: rtl/ifu_prefetch.sv
// Instruction fetch unit with a prefetch FIFO.
// Issues one fetch at a time to instruction memory, buffers returned words
// with their PCs, and hands them to decode over a valid/ready interface.
// A redirect flushes the buffer and discards any fetch still in flight.
module ifu_prefetch #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(64'h8000_0000),
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [31:0]     inst_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // REQ: nothing in flight, WAIT: fetch in flight and wanted,
  // DROP: fetch in flight whose result must be thrown away.
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t           state;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  req_pc;
  logic [XLEN-1:0]  redirect_target;

  logic [XLEN-1:0]  pc_mem   [FIFO_DEPTH];
  logic [31:0]      data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic empty;
  logic full;
  logic req_fire;
  logic push;
  logic pop;

  assign redirect_target = redirect_pc & ~XLEN'(3);

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(FIFO_DEPTH));

  // Outputs are forced to their idle values while reset is held, so the
  // interface looks quiet even before the first clock edge.
  assign imem_req_valid = !rst && (state == REQ) && !full && !redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign inst_valid     = !rst && !empty && !redirect_valid;
  assign inst_pc        = rst ? '0 : pc_mem[rd_ptr];
  assign inst_data      = rst ? '0 : data_mem[rd_ptr];

  assign req_fire = imem_req_valid && imem_req_ready;
  assign push     = (state == WAIT) && imem_resp_valid && !redirect_valid;
  assign pop      = inst_valid && inst_ready;

  // Fetch sequencing: one outstanding request, redirect overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
      case (state)
        WAIT:    state <= imem_resp_valid ? REQ : DROP;
        DROP:    state <= imem_resp_valid ? REQ : DROP;
        default: state <= REQ;
      endcase
    end else begin
      case (state)
        REQ: begin
          if (req_fire) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + XLEN'(4);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid) state <= REQ;
        end
        DROP: begin
          if (imem_resp_valid) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  // Buffer storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= req_pc;
      data_mem[wr_ptr] <= imem_resp_data;
    end
  end

  // Buffer bookkeeping: flush on redirect, otherwise push/pop independently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomized bench for ifu_prefetch. The reference keeps the prefetch
// buffer as a queue of PCs, a single in-flight fetch with a random latency,
// and the next PC to be requested; instruction words come from a hash of
// the address so every delivered word can be checked against its PC.
module tb_ifu_prefetch;

  localparam int          XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [63:0] inst_pc;
  logic [31:0] inst_data;

  ifu_prefetch #(
    .XLEN(XLEN),
    .RESET_PC(RESET_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_pc(inst_pc),
    .inst_data(inst_data)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [63:0] buf_q[$];
  logic [63:0] next_req_addr;
  logic [63:0] inflight_addr;
  bit          inflight;
  bit          wanted;
  int          lat;
  bit          resp_now;

  function automatic logic [31:0] memfn(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    buf_q.delete();
    next_req_addr = RESET_PC;
    inflight      = 1'b0;
    wanted        = 1'b0;
    lat           = 0;
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge,
  // then advance the reference model with the events of that cycle.
  task automatic applyStimulus(input bit redir, input logic [63:0] tgt,
                               input bit iready, input bit rready);
    bit exp_rv;
    bit exp_iv;
    bit fire;
    bit pop;
    redirect_valid = redir;
    redirect_pc    = tgt;
    inst_ready     = iready;
    imem_req_ready = rready;
    resp_now       = 1'b0;
    if (inflight) begin
      if (lat == 0) resp_now = 1'b1;
      else lat--;
    end
    imem_resp_valid = resp_now;
    imem_resp_data  = resp_now ? memfn(inflight_addr) : 32'($urandom);

    @(negedge clk);
    exp_rv = !inflight && (buf_q.size() < DEPTH) && !redir;
    exp_iv = (buf_q.size() > 0) && !redir;
    checkOutput("req_valid", 64'(imem_req_valid), 64'(exp_rv));
    if (exp_rv) checkOutput("req_addr", imem_req_addr, next_req_addr);
    checkOutput("inst_valid", 64'(inst_valid), 64'(exp_iv));
    if (exp_iv) begin
      checkOutput("inst_pc", inst_pc, buf_q[0]);
      checkOutput("inst_data", 64'(inst_data), 64'(memfn(buf_q[0])));
    end
    fire = exp_rv && rready;
    pop  = exp_iv && iready;

    @(posedge clk);
    if (redir) begin
      buf_q.delete();
      if (inflight && !resp_now) wanted = 1'b0;
      next_req_addr = tgt & ~64'h3;
    end else begin
      if (pop) void'(buf_q.pop_front());
      if (resp_now && wanted) buf_q.push_back(inflight_addr);
    end
    if (resp_now) inflight = 1'b0;
    if (fire) begin
      inflight      = 1'b1;
      wanted        = 1'b1;
      inflight_addr = next_req_addr;
      next_req_addr = next_req_addr + 64'd4;
      lat           = int'($urandom_range(0, 2));
    end
    #1;
  endtask

  task automatic waitInflight(input bit iready);
    for (int i = 0; i < 20 && !inflight; i++) applyStimulus(1'b0, '0, iready, 1'b1);
    checkOutput("reach_wait", 64'(inflight), 64'd1);
  endtask

  initial begin
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    inst_ready      = 1'b0;
    resetModel();

    #1;
    checkOutput("rst_req_valid", 64'(imem_req_valid), 64'd0);
    checkOutput("rst_inst_valid", 64'(inst_valid), 64'd0);
    checkOutput("rst_req_addr", imem_req_addr, RESET_PC);
    checkOutput("rst_inst_pc", inst_pc, 64'd0);
    checkOutput("rst_inst_data", 64'(inst_data), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Streaming with decode always ready.
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);

    // Decode stalls until the buffer is full, then drains.
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);

    // Redirect while a fetch is outstanding with no response that cycle.
    waitInflight(1'b1);
    lat = 2;
    applyStimulus(1'b1, 64'h8000_1003, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);

    // Redirect into DROP, then redirect again while still dropping.
    waitInflight(1'b1);
    lat = 2;
    applyStimulus(1'b1, 64'h8000_1003, 1'b1, 1'b1);
    applyStimulus(1'b1, 64'h8000_2006, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);

    // Redirect coinciding with the response.
    waitInflight(1'b1);
    lat = 0;
    applyStimulus(1'b1, 64'h8000_3001, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);

    // Redirect while popping with three buffered entries.
    for (int i = 0; i < 40 && buf_q.size() != 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("fill_three", 64'(buf_q.size()), 64'd3);
    applyStimulus(1'b1, 64'h8000_4000, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);

    // Fetch PC wraps past the top of the address space.
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 15) == 0), {$urandom, $urandom},
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
    end

    // Asynchronous reset while a fetch is outstanding.
    waitInflight(1'b1);
    lat = 2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_req_valid", 64'(imem_req_valid), 64'd0);
    checkOutput("mid_rst_inst_valid", 64'(inst_valid), 64'd0);
    checkOutput("mid_rst_req_addr", imem_req_addr, RESET_PC);
    checkOutput("mid_rst_inst_pc", inst_pc, 64'd0);
    checkOutput("mid_rst_inst_data", 64'(inst_data), 64'd0);
    resetModel();
    @(negedge clk);
    rst             = 1'b0;
    redirect_valid  = 1'b0;
    imem_req_ready  = 1'b0;
    inst_ready      = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    #1;
    checkOutput("post_rst_req_valid", 64'(imem_req_valid), 64'd1);
    checkOutput("post_rst_req_addr", imem_req_addr, RESET_PC);
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Parametrised instruction fetch unit with a request/response memory interface and a FIFO prefetch buffer.
- Presents a valid/ready instruction stream to decode.
- Supports redirect: an EXU branch or jump flushes the buffer and discards any in-flight fetch.
- Successor to the single-cycle fetch stage; sits between the PC/redirect logic and IDU.

Parameters:
XLEN, 64, address/PC width in bits
RESET_PC, 64'h80000000 (XLEN wide), fetch PC after reset
FIFO_DEPTH, 4, prefetch buffer entries; power of two, >= 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset: asynchronous, active-high
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  XLEN  new fetch PC; bits [1:0] are ignored (treated as 0)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address (current fetch_pc)
imem_resp_valid  in  1  response data valid; always accepted, no ready
imem_resp_data  in  32  fetched instruction word
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst_pc  out  XLEN  PC of the head instruction
inst_data  out  32  head instruction word

Behaviour:
- Reset (async, any time, including mid-transaction):
  - fetch_pc = RESET_PC, req_pc = 0, state = REQ, FIFO empty (count 0, pointers 0).
  - While rst is high: imem_req_valid = 0, inst_valid = 0, imem_req_addr = RESET_PC, inst_pc/inst_data = 0.
  - A response arriving for a pre-reset request is ignored.
- FSM states:
  - REQ: no fetch in flight.
  - WAIT: one fetch in flight, result wanted.
  - DROP: one fetch in flight, result to be discarded.
  - At most one request is outstanding at any time.
- imem_req_valid = (state==REQ) && (count < FIFO_DEPTH) && !redirect_valid. Once asserted, it stays high with a stable address until the handshake or a redirect.
- Request handshake (valid && ready) in REQ:
  - req_pc <= fetch_pc; fetch_pc <= fetch_pc + 4, modulo 2^XLEN (wraps to 0); state -> WAIT.
  - Memory latency is >= 1 cycle; imem_resp_valid is never asserted in the handshake cycle.
- WAIT with imem_resp_valid: push {req_pc, imem_resp_data} into the FIFO; state -> REQ.
  - Space is guaranteed: an issue requires count < FIFO_DEPTH, and count cannot grow while in flight.
- DROP with imem_resp_valid: discard the data; state -> REQ.
- Redirect (redirect_valid = 1), highest priority:
  - FIFO flushed (count 0); fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - From REQ: stay REQ; the request is suppressed that cycle.
  - From WAIT without a response: -> DROP.
  - From WAIT with a response in the same cycle: data discarded, -> REQ.
  - From DROP without a response: stay DROP. With a response: -> REQ.
- Output side:
  - inst_valid = !empty && !redirect_valid.
  - inst_pc/inst_data come from the FIFO head; contents are combinational from storage and stable while inst_valid && !inst_ready.
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle: count unchanged; works both full and empty (an empty FIFO does not bypass, so first-word latency is response + 1 cycle).
- Pointers wrap modulo FIFO_DEPTH.
- Throughput: at most one instruction per 2 cycles with 1-cycle memory latency (single outstanding request).

Test Plan:
- Reset release, memory ready and 1-cycle latency, inst_ready=1 -> requests at 80000000, 80000004, 80000008; decode receives the same PCs in order with matching data.
- inst_ready=0 held -> exactly 4 words buffered (count=4), imem_req_valid stays 0; raise inst_ready -> drains 4 entries, fetching resumes at 80000010.
- Redirect to 80001003 while in WAIT -> next response dropped, next request addr 80001000, first inst_pc 80001000, no stale PC delivered.
- Redirect in the same cycle as a response, and a redirect while in DROP -> no stale entry; fetch resumes at the last redirect target.
- Redirect in the same cycle as inst_valid && inst_ready with FIFO holding 3 entries -> inst_valid 0 that cycle, FIFO empty the next cycle.
- XLEN=32, RESET_PC=FFFFFFFC -> second request addr 00000000; assert rst while in WAIT -> outputs at reset values immediately, fetch restarts at FFFFFFFC.
